// File: rtl/modmul_pkg.sv
// Shared state type and sizing helpers for the modular-multiplier datapath.
package modmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    OUT,
    DONE
  } dsm_state_t;

  // Number of B digits consumed by the serial multiplier.
  function automatic int unsigned dsm_digits(input int unsigned logq, input int unsigned dw);
    return logq / dw;
  endfunction

  // Cycles from the accept edge to the out_valid rise.
  function automatic int unsigned dsm_lat(input int unsigned logq, input int unsigned dw,
                                          input int unsigned ff_out);
    return dsm_digits(logq, dw) + ff_out;
  endfunction

endpackage

// File: rtl/digit_serial_mult_mac.sv
// One digit step of the serial multiplier: acc + (a * digit) << (idx * DW).
module digit_mac #(
  parameter int unsigned LOGQ = 64,
  parameter int unsigned DW   = 16,
  parameter int unsigned CW   = 2
) (
  input  logic [LOGQ-1:0]   a,
  input  logic [DW-1:0]     digit,
  input  logic [CW-1:0]     idx,
  input  logic [2*LOGQ-1:0] acc,
  output logic [2*LOGQ-1:0] acc_nxt_c
);

  localparam int unsigned AW = 2 * LOGQ;
  localparam int unsigned PW = LOGQ + DW;
  localparam int unsigned SW = $clog2(AW) + 1;

  logic [PW-1:0] prod;
  logic [SW-1:0] shamt;

  always_comb begin
    prod      = PW'(a) * PW'(digit);
    shamt     = SW'(idx) * SW'(DW);
    acc_nxt_c = acc + (AW'(prod) << shamt);
  end

endmodule

// File: rtl/digit_serial_mult.sv
// Digit-serial A*B multiplier with valid/ready handshake; the modulus side-band
// travels with the operands so the reduction stage sees aligned parameters.
module digit_serial_mult
  import modmul_pkg::*;
#(
  parameter int unsigned LOGQ   = 64,
  parameter int unsigned LOGQH  = 32,
  parameter int unsigned LOGL1  = 5,
  parameter int unsigned LOGL2  = 5,
  parameter int unsigned LOGL3  = 5,
  parameter int unsigned DW     = 16,
  parameter int unsigned FF_OUT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LOGQ-1:0]     A,
  input  logic [LOGQ-1:0]     B,
  input  logic [LOGQH-1:0]    qH_i,
  input  logic [LOGL1-1:0]    L1_i,
  input  logic [LOGL2-1:0]    L2_i,
  input  logic [LOGL3-1:0]    L3_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*LOGQ-1:0]   C,
  output logic [LOGQH-1:0]    qH_o,
  output logic [LOGL1-1:0]    L1_o,
  output logic [LOGL2-1:0]    L2_o,
  output logic [LOGL3-1:0]    L3_o
);

  localparam int unsigned ND = dsm_digits(LOGQ, DW);
  localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned AW = 2 * LOGQ;

  if (LOGQ % DW != 0) begin : g_bad_dw
    $error("digit_serial_mult: LOGQ must be a multiple of DW");
  end

  dsm_state_t        state, state_nxt;
  logic              accept, mac_en, load_out;
  logic [CW-1:0]     cnt;
  logic [LOGQ-1:0]   a_q, b_q;
  logic [AW-1:0]     acc, acc_nxt;
  logic [DW-1:0]     digit;
  logic [LOGQH-1:0]  qh_q;
  logic [LOGL1-1:0]  l1_q;
  logic [LOGL2-1:0]  l2_q;
  logic [LOGL3-1:0]  l3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake; DONE can retire and accept on the same edge.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    mac_en    = 1'b0;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        mac_en = 1'b1;
        if (cnt == CW'(ND - 1)) begin
          state_nxt = (FF_OUT != 0) ? OUT : DONE;
          load_out  = (FF_OUT == 0);
        end
      end
      OUT: begin
        state_nxt = DONE;
        load_out  = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = MUL;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    digit = DW'(b_q >> (32'(cnt) * DW));
  end

  digit_mac #(
    .LOGQ (LOGQ),
    .DW   (DW),
    .CW   (CW)
  ) u_mac (
    .a         (a_q),
    .digit     (digit),
    .idx       (cnt),
    .acc       (acc),
    .acc_nxt_c (acc_nxt)
  );

  // Operand capture and accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      qh_q <= '0;
      l1_q <= '0;
      l2_q <= '0;
      l3_q <= '0;
      cnt  <= '0;
      acc  <= '0;
    end else if (accept) begin
      a_q  <= A;
      b_q  <= B;
      qh_q <= qH_i;
      l1_q <= L1_i;
      l2_q <= L2_i;
      l3_q <= L3_i;
      cnt  <= '0;
      acc  <= '0;
    end else if (mac_en) begin
      acc  <= acc_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  // Result and side-band only change on entry to DONE, so they hold under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      C         <= '0;
      qH_o      <= '0;
      L1_o      <= '0;
      L2_o      <= '0;
      L3_o      <= '0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (load_out) begin
        C    <= (FF_OUT != 0) ? acc : acc_nxt;
        qH_o <= qh_q;
        L1_o <= l1_q;
        L2_o <= l2_q;
        L3_o <= l3_q;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_mult.sv
// Directed and randomized checks of digit_serial_mult (LOGQ=64, DW=16, FF_OUT=1).
module tb_digit_serial_mult;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  A = '0;
  logic [63:0]  B = '0;
  logic [31:0]  qH_i = '0;
  logic [4:0]   L1_i = '0;
  logic [4:0]   L2_i = '0;
  logic [4:0]   L3_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] C;
  logic [31:0]  qH_o;
  logic [4:0]   L1_o;
  logic [4:0]   L2_o;
  logic [4:0]   L3_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_mult #(
    .LOGQ(64), .LOGQH(32), .LOGL1(5), .LOGL2(5), .LOGL3(5), .DW(16), .FF_OUT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .qH_i(qH_i), .L1_i(L1_i), .L2_i(L2_i), .L3_i(L3_i),
    .out_valid(out_valid), .out_ready(out_ready), .C(C),
    .qH_o(qH_o), .L1_o(L1_o), .L2_o(L2_o), .L3_o(L3_o)
  );

  // Present an operand set and hold in_valid until it is taken; returns just after the accept edge.
  task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic [31:0] qh,
                          input logic [4:0] l1, input logic [4:0] l2, input logic [4:0] l3,
                          output bit ok);
    ok = 1'b0;
    A = a; B = b; qH_i = qh; L1_i = l1; L2_i = l2; L3_i = l3;
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the previous accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_out(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (C !== 128'd0) begin errors++; $display("FAIL reset_c got %h exp 0", C); end
    checks++; if (qH_o !== 32'd0) begin errors++; $display("FAIL reset_qh got %h exp 0", qH_o); end
    checks++; if ({L1_o, L2_o, L3_o} !== 15'd0) begin errors++; $display("FAIL reset_l got %h exp 0", {L1_o, L2_o, L3_o}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    bit rdy_seen;
    int lat;
    out_ready = 1'b1;
    drive_op(64'd3, 64'd5, 32'd0, 5'd0, 5'd0, 5'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept got timeout exp accept"); end
    rdy_seen = in_ready;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (in_ready) rdy_seen = 1'b1;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL basic_busy_ready got %b exp 0", rdy_seen); end
    checks++; if (C !== 128'd15) begin errors++; $display("FAIL basic_c got %h exp %h", C, 128'd15); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", out_valid); end
  endtask

  task automatic test_max();
    bit ok;
    int lat;
    out_ready = 1'b1;
    drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 5'd0, 5'd0, 5'd0, ok);
    wait_out(lat);
    checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL max_latency got %0d exp 5", lat); end
    checks++;
    if (C !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      errors++; $display("FAIL max_c got %h exp %h", C, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit held;
    int lat;
    out_ready = 1'b0;
    drive_op(64'h1234, 64'hDEAD_BEEF, 32'd0, 5'd0, 5'd0, 5'd0, ok);
    A = 64'd2; B = 64'd2; in_valid = 1'b1;
    wait_out(lat);
    checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL bp_latency got %0d exp 5", lat); end
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || C !== 128'h0FD5_72B7_968C || in_ready !== 1'b0) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL bp_hold got %b exp 1 (C %h)", held, C); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_on_retire got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_retire got valid %b ready %b exp 0 0", out_valid, in_ready);
    end
    wait_out(lat);
    checks++; if (lat !== 5 || C !== 128'd4) begin errors++; $display("FAIL bp_second got lat %0d C %h exp 5 4", lat, C); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    out_ready = 1'b1;
    drive_op(64'd2, 64'd3, 32'd0, 5'd0, 5'd0, 5'd0, ok);
    A = 64'd7; B = 64'd11; in_valid = 1'b1;
    wait_out(lat);
    checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL b2b_lat1 got %0d exp 5", lat); end
    checks++; if (C !== 128'd6) begin errors++; $display("FAIL b2b_c1 got %h exp 6", C); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle1 got %b exp 0", out_valid); end
    wait_out(lat);
    checks++; if (lat !== 5 || C !== 128'd77) begin errors++; $display("FAIL b2b_c2 got lat %0d C %h exp 5 77", lat, C); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle2 got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit leaked;
    int lat;
    out_ready = 1'b1;
    drive_op(64'd123, 64'd456, 32'd0, 5'd0, 5'd0, 5'd0, ok);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state got valid %b ready %b exp 0 1", out_valid, in_ready);
    end
    checks++; if (C !== 128'd0) begin errors++; $display("FAIL midrst_c got %h exp 0", C); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) leaked = 1'b1;
    end
    checks++; if (leaked !== 1'b0) begin errors++; $display("FAIL midrst_no_output got %b exp 0", leaked); end
    drive_op(64'd9, 64'd9, 32'd0, 5'd0, 5'd0, 5'd0, ok);
    wait_out(lat);
    checks++; if (!ok || lat !== 5 || C !== 128'd81) begin
      errors++; $display("FAIL midrst_next got lat %0d C %h exp 5 81", lat, C);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sideband();
    bit ok;
    int lat;
    out_ready = 1'b1;
    drive_op(64'd10, 64'd10, 32'hABCD_0001, 5'd17, 5'd3, 5'd30, ok);
    qH_i = 32'h1111_2222; L1_i = 5'd2; L2_i = 5'd9; L3_i = 5'd1;
    wait_out(lat);
    checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL sb_latency got %0d exp 5", lat); end
    checks++; if (qH_o !== 32'hABCD_0001) begin errors++; $display("FAIL sb_qh got %h exp abcd0001", qH_o); end
    checks++; if (L1_o !== 5'd17) begin errors++; $display("FAIL sb_l1 got %0d exp 17", L1_o); end
    checks++; if (L2_o !== 5'd3 || L3_o !== 5'd30) begin
      errors++; $display("FAIL sb_l23 got %0d %0d exp 3 30", L2_o, L3_o);
    end
    checks++; if (C !== 128'd100) begin errors++; $display("FAIL sb_c got %h exp 100", C); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok;
    int lat;
    int stall;
    logic [63:0]  ra, rb;
    logic [31:0]  rq;
    logic [127:0] exp_c;
    for (int n = 0; n < 2000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rq = $urandom;
      if (n % 7 == 0) rb = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_c = {64'd0, ra} * {64'd0, rb};
      stall = $urandom_range(0, 2);
      out_ready = 1'b1;
      drive_op(ra, rb, rq, 5'(n), 5'(n + 1), 5'(n + 2), ok);
      if (stall > 0) out_ready = 1'b0;
      wait_out(lat);
      repeat (stall) begin @(posedge clk); #1; end
      checks++;
      if (!ok || lat !== 5 || out_valid !== 1'b1 || C !== exp_c || qH_o !== rq) begin
        errors++;
        $display("FAIL rand_%0d got lat %0d C %h qh %h exp 5 %h %h", n, lat, C, qH_o, exp_c, rq);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sideband();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
